// File: rtl/spi_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_capture_ctrl_if
//
// Bundles the SPI word interface, the controller's configuration outputs and
// the ADC capture FIFO handshake into one interface.
//
//   slave  : view used by spi_capture_ctrl (consumes rx words and FIFO status,
//            drives tx words, configuration and FIFO control).
//   master : view used by the environment (SPI slave core + FIFO).
//
// Signals
//   rx_valid, rx_data        one-cycle strobe with the received SPI word
//   tx_data                  registered word for the next SPI transfer
//   ch_sel, ch_sel_valid     selected ADC channel and its valid flag
//   sample_freq, sample_num  sample frequency word, points per capture
//   fifo_aclr, fifo_wr_en    FIFO clear and capture write enable
//   fifo_wr_count            FIFO used words (write side)
//   fifo_rd_data, fifo_rdempty, fifo_rdreq   show-ahead FIFO read port
//   busy, err_pulse          controller status
// ---------------------------------------------------------------------------
interface spi_capture_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int NUM_CH = 4,
    parameter int FREQ_W = 32,
    parameter int CNT_W  = 13
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              rx_valid;
    logic [WORD_W-1:0] rx_data;
    logic [WORD_W-1:0] tx_data;
    logic [CH_W-1:0]   ch_sel;
    logic              ch_sel_valid;
    logic [FREQ_W-1:0] sample_freq;
    logic [15:0]       sample_num;
    logic              fifo_aclr;
    logic              fifo_wr_en;
    logic [CNT_W-1:0]  fifo_wr_count;
    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_rdempty;
    logic              fifo_rdreq;
    logic              busy;
    logic              err_pulse;

    modport slave (
        input  rx_valid, rx_data, fifo_wr_count, fifo_rd_data, fifo_rdempty,
        output tx_data, ch_sel, ch_sel_valid, sample_freq, sample_num,
               fifo_aclr, fifo_wr_en, fifo_rdreq, busy, err_pulse
    );

    modport master (
        output rx_valid, rx_data, fifo_wr_count, fifo_rd_data, fifo_rdempty,
        input  tx_data, ch_sel, ch_sel_valid, sample_freq, sample_num,
               fifo_aclr, fifo_wr_en, fifo_rdreq, busy, err_pulse
    );
endinterface

// File: rtl/spi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// spi_capture_ctrl
//
// Command/readout controller between an SPI slave word interface and an
// N-channel ADC capture FIFO. Host packets select a channel, load the sample
// frequency word and the point count; a read transaction clears the FIFO,
// captures sample_num points, streams them out word by word and finishes
// with an end handshake. Any 0xDEAD word outside IDLE aborts.
//
// Ports
//   clk    system clock (SPI words arrive as single-cycle strobes)
//   rst_n  asynchronous active-low reset
//   bus    spi_capture_ctrl_if.slave (see interface file for signal list)
//
// Build option
//   CAPTURE_CHECKSUM_EN : when defined, a 16-bit sum of the popped words is
//   sent after the last data word and before the 0xDCBA tail marker.
// ---------------------------------------------------------------------------
module spi_capture_ctrl #(
    parameter int WORD_W         = 16,
    parameter int NUM_CH         = 4,
    parameter int FREQ_W         = 32,
    parameter int CNT_W          = 13,
    parameter int DEFAULT_POINTS = 512,
    parameter int CLR_CYC        = 4
) (
    input logic               clk,
    input logic               rst_n,
    spi_capture_ctrl_if.slave bus
);
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FREQ_WORDS = FREQ_W / WORD_W;
    localparam int FC_W       = (FREQ_WORDS > 1) ? $clog2(FREQ_WORDS) : 1;
    localparam int CC_W       = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    localparam logic [31:0] PTS_MAX  = (32'd1 << CNT_W) - 32'd1;
    localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

    localparam logic [WORD_W-1:0] C_OPEN     = WORD_W'(16'hAABB);
    localparam logic [WORD_W-1:0] C_CLOSE    = WORD_W'(16'hBBAA);
    localparam logic [WORD_W-1:0] C_READ     = WORD_W'(16'hCCDD);
    localparam logic [WORD_W-1:0] C_SEL      = WORD_W'(16'hCA01);
    localparam logic [WORD_W-1:0] C_FREQ     = WORD_W'(16'hCA02);
    localparam logic [WORD_W-1:0] C_PTS      = WORD_W'(16'hCA03);
    localparam logic [WORD_W-1:0] C_SEL_BASE = WORD_W'(16'hADC0);
    localparam logic [WORD_W-1:0] C_ABORT    = WORD_W'(16'hDEAD);
    localparam logic [WORD_W-1:0] C_WAIT     = WORD_W'(16'hABAD);
    localparam logic [WORD_W-1:0] C_READY    = WORD_W'(16'hABCD);
    localparam logic [WORD_W-1:0] C_END      = WORD_W'(16'hDCBA);
    localparam logic [WORD_W-1:0] C_ACK      = WORD_W'(16'hDCAB);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_SEL, S_FREQ, S_PTS, S_CLR, S_ARM, S_TX, S_TAIL
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              ch_valid_q, ch_valid_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       remain_q, remain_d;
    logic [FC_W-1:0]   freq_cnt_q, freq_cnt_d;
    logic [CC_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic              aclr_q, aclr_d;
    logic              wr_en_q, wr_en_d;
    logic              rdreq_q, rdreq_d;
    logic              err_q, err_d;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic              sum_sent_q, sum_sent_d;
`endif

    // Offset of a select code from the channel base; codes below the base
    // wrap to large values and fail the range check.
    logic [WORD_W-1:0] sel_off;
    assign sel_off = bus.rx_data - C_SEL_BASE;

    logic rx_abort;
    assign rx_abort = bus.rx_valid && (bus.rx_data == C_ABORT);

    logic capture_done;
    assign capture_done = (32'(bus.fifo_wr_count) >= 32'(num_q));

    // NOTE: every register is written with <= so all of them sample the
    // pre-edge values together, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_q       <= '0;
            ch_sel_q   <= '0;
            ch_valid_q <= 1'b0;
            freq_q     <= '0;
            num_q      <= 16'(DEFAULT_POINTS);
            remain_q   <= '0;
            freq_cnt_q <= '0;
            clr_cnt_q  <= '0;
            aclr_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rdreq_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            sum_q      <= '0;
            sum_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ch_sel_q   <= ch_sel_d;
            ch_valid_q <= ch_valid_d;
            freq_q     <= freq_d;
            num_q      <= num_d;
            remain_q   <= remain_d;
            freq_cnt_q <= freq_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            aclr_q     <= aclr_d;
            wr_en_q    <= wr_en_d;
            rdreq_q    <= rdreq_d;
            err_q      <= err_d;
`ifdef CAPTURE_CHECKSUM_EN
            sum_q      <= sum_d;
            sum_sent_q <= sum_sent_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch. Pulse outputs default low.
        state_d    = state_q;
        tx_d       = tx_q;
        ch_sel_d   = ch_sel_q;
        ch_valid_d = ch_valid_q;
        freq_d     = freq_q;
        num_d      = num_q;
        remain_d   = remain_q;
        freq_cnt_d = freq_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        aclr_d     = 1'b0;
        wr_en_d    = 1'b0;
        rdreq_d    = 1'b0;
        err_d      = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
        sum_d      = sum_q;
        sum_sent_d = sum_sent_q;
`endif

        if (state_q != S_IDLE && rx_abort) begin
            // Abort outranks every other decode, including the ARM exit.
            state_d = S_IDLE;
            tx_d    = '0;
            aclr_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_d = '0;
                    if (bus.rx_valid) begin
                        if (bus.rx_data == C_OPEN) begin
                            state_d = S_CMD;
                        end else if (bus.rx_data == C_READ) begin
                            if (ch_valid_q) begin
                                state_d   = S_CLR;
                                tx_d      = C_WAIT;
                                aclr_d    = 1'b1;
                                clr_cnt_d = CC_W'(CLR_CYC - 1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end

                S_CMD: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == C_SEL) begin
                            state_d = S_SEL;
                        end else if (bus.rx_data == C_FREQ) begin
                            state_d    = S_FREQ;
                            freq_cnt_d = FC_W'(FREQ_WORDS - 1);
                        end else if (bus.rx_data == C_PTS) begin
                            state_d = S_PTS;
                        end else if (bus.rx_data == C_CLOSE) begin
                            state_d = S_IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_SEL: begin
                    if (bus.rx_valid) begin
                        state_d = S_CMD;
                        if (32'(sel_off) < NUM_CH_U) begin
                            ch_sel_d   = sel_off[CH_W-1:0];
                            ch_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_FREQ: begin
                    if (bus.rx_valid) begin
                        // MSW first; older bits fall off the top.
                        freq_d = (freq_q << WORD_W) | FREQ_W'(bus.rx_data);
                        if (freq_cnt_q == '0) begin
                            state_d = S_CMD;
                        end else begin
                            freq_cnt_d = freq_cnt_q - 1'b1;
                        end
                    end
                end

                S_PTS: begin
                    if (bus.rx_valid) begin
                        state_d = S_CMD;
                        if (bus.rx_data == '0) begin
                            err_d = 1'b1;
                        end else if (32'(bus.rx_data) > PTS_MAX) begin
                            num_d = 16'(PTS_MAX);
                        end else begin
                            num_d = 16'(bus.rx_data);
                        end
                    end
                end

                S_CLR: begin
                    if (clr_cnt_q == '0) begin
                        state_d = S_ARM;
                        wr_en_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q - 1'b1;
                        aclr_d    = 1'b1;
                    end
                end

                S_ARM: begin
                    // Autonomous exit; any coincident word is dropped.
                    if (capture_done) begin
                        state_d  = S_TX;
                        tx_d     = C_READY;
                        remain_d = num_q;
`ifdef CAPTURE_CHECKSUM_EN
                        sum_d      = '0;
                        sum_sent_d = 1'b0;
`endif
                    end else begin
                        wr_en_d = 1'b1;
                    end
                end

                S_TX: begin
                    if (bus.rx_valid) begin
                        if (remain_q != '0) begin
                            remain_d = remain_q - 16'd1;
                            if (bus.fifo_rdempty) begin
                                tx_d  = '0;
                                err_d = 1'b1;
                            end else begin
                                tx_d    = bus.fifo_rd_data;
                                rdreq_d = 1'b1;
`ifdef CAPTURE_CHECKSUM_EN
                                sum_d = sum_q + 16'(bus.fifo_rd_data);
`endif
                            end
                        end else begin
`ifdef CAPTURE_CHECKSUM_EN
                            if (!sum_sent_q) begin
                                tx_d       = WORD_W'(sum_q);
                                sum_sent_d = 1'b1;
                            end else begin
                                tx_d    = C_END;
                                state_d = S_TAIL;
                            end
`else
                            tx_d    = C_END;
                            state_d = S_TAIL;
`endif
                        end
                    end
                end

                S_TAIL: begin
                    if (bus.rx_valid) begin
                        tx_d = '0;
                        if (bus.rx_data == C_ACK) begin
                            state_d    = S_IDLE;
                            aclr_d     = 1'b1;
                            ch_valid_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data      = tx_q;
    assign bus.ch_sel       = ch_sel_q;
    assign bus.ch_sel_valid = ch_valid_q;
    assign bus.sample_freq  = freq_q;
    assign bus.sample_num   = num_q;
    assign bus.fifo_aclr    = aclr_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_rdreq   = rdreq_q;
    assign bus.err_pulse    = err_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_capture_ctrl.sv
`timescale 1ns/1ps
module tb_spi_capture_ctrl;
    localparam int WORD_W         = 16;
    localparam int NUM_CH         = 4;
    localparam int FREQ_W         = 32;
    localparam int CNT_W          = 13;
    localparam int DEFAULT_POINTS = 512;
    localparam int CLR_CYC        = 4;
    localparam int PTS_MAX        = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_capture_ctrl_if #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) bus ();

    spi_capture_ctrl #(
        .WORD_W(WORD_W), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .CNT_W(CNT_W),
        .DEFAULT_POINTS(DEFAULT_POINTS), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- show-ahead FIFO model (runs on the falling edge) -----
    // Written only by the stimulus block:
    logic [15:0] fill_src[$];
    int          fill_gen   = 0;
    int          drop_after = 0;   // 0: no loss; N: contents vanish after N pops
    // Written only by the model:
    logic [15:0] fifo_q[$];
    int          last_gen    = 0;
    int          push_idx    = 0;
    int          pops        = 0;
    int          aclr_cycles = 0;
    int          rdreq_count = 0;

    always @(negedge clk) begin
        if (fill_gen != last_gen) begin
            last_gen = fill_gen;
            push_idx = 0;
            pops     = 0;
        end
        if (bus.fifo_rdreq === 1'b1) rdreq_count++;
        if (bus.fifo_aclr === 1'b1) begin
            aclr_cycles++;
            fifo_q.delete();
        end else begin
            if (bus.fifo_rdreq === 1'b1 && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
                if (drop_after != 0 && pops == drop_after) fifo_q.delete();
            end
            if (bus.fifo_wr_en === 1'b1 && push_idx < fill_src.size()) begin
                fifo_q.push_back(fill_src[push_idx]);
                push_idx++;
            end
        end
        bus.fifo_wr_count <= CNT_W'(fifo_q.size());
        bus.fifo_rd_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
        bus.fifo_rdempty  <= (fifo_q.size() == 0);
    end

    // ---------------- checking helpers --------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe, then return on the following falling edge where the
    // results of the strobe edge are visible; the next call adds a gap cycle.
    task automatic send(input logic [15:0] w);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = w;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [15:0] filler();
        return 16'($urandom_range(0, 16'h7FFF));   // never the abort code
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"},      bus.tx_data,      32'h0);
        check({tag, "_ch"},      bus.ch_sel,       32'h0);
        check({tag, "_chv"},     bus.ch_sel_valid, 32'h0);
        check({tag, "_freq"},    bus.sample_freq,  32'h0);
        check({tag, "_num"},     bus.sample_num,   32'(DEFAULT_POINTS));
        check({tag, "_aclr"},    bus.fifo_aclr,    32'h0);
        check({tag, "_wren"},    bus.fifo_wr_en,   32'h0);
        check({tag, "_rdreq"},   bus.fifo_rdreq,   32'h0);
        check({tag, "_busy"},    bus.busy,         32'h0);
        check({tag, "_err"},     bus.err_pulse,    32'h0);
    endtask

    task automatic configure(input int ch, input int n);
        send(16'hAABB);
        send(16'hCA01);
        send(16'(16'hADC0 + ch));
        send(16'hCA03);
        send(16'(n));
        send(16'hBBAA);
    endtask

    // Full read transaction. Reference: the host sees ABAD while capturing,
    // ABCD once n words are in, then the FIFO words in order; words lost to
    // underrun read as 0 with an error and no pop; (optional sum); DCBA.
    task automatic do_read(input string tag, input int n, input logic [15:0] data[$], input int drop);
        int          keep, ac0, rq0, waited;
        logic [15:0] sum;
        keep = (drop == 0 || drop > n) ? n : drop;
        sum  = 16'h0;
        for (int i = 0; i < keep; i++) sum = sum + data[i];

        fill_src   = data;
        drop_after = drop;
        fill_gen   = fill_gen + 1;
        ac0        = aclr_cycles;

        send(16'hCCDD);
        check({tag, "_clr_tx"},   bus.tx_data,   32'hABAD);
        check({tag, "_clr_busy"}, bus.busy,      32'h1);
        check({tag, "_clr_aclr"}, bus.fifo_aclr, 32'h1);

        waited = 0;
        while (bus.tx_data !== 16'hABCD && waited < 200) begin
            if (bus.tx_data !== 16'hABAD) check({tag, "_poll_tx"}, bus.tx_data, 32'hABAD);
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"},     bus.tx_data,       32'hABCD);
        check({tag, "_aclr_len"},  aclr_cycles - ac0, 32'(CLR_CYC));
        check({tag, "_wren_off"},  bus.fifo_wr_en,    32'h0);

        rq0 = rdreq_count;
        for (int i = 0; i < n; i++) begin
            send(filler());
            check($sformatf("%s_word%0d", tag, i), bus.tx_data, (i < keep) ? 32'(data[i]) : 32'h0);
            check($sformatf("%s_err%0d", tag, i), bus.err_pulse, (i < keep) ? 32'h0 : 32'h1);
        end
`ifdef CAPTURE_CHECKSUM_EN
        send(filler());
        check({tag, "_sum"}, bus.tx_data, 32'(sum));
`endif
        send(filler());
        check({tag, "_end"},   bus.tx_data,         32'hDCBA);
        check({tag, "_pops"},  rdreq_count - rq0,   32'(keep));
        send(16'hDCAB);
        check({tag, "_ack_tx"},   bus.tx_data,      32'h0);
        check({tag, "_ack_aclr"}, bus.fifo_aclr,    32'h1);
        check({tag, "_ack_chv"},  bus.ch_sel_valid, 32'h0);
        check({tag, "_ack_busy"}, bus.busy,         32'h0);
    endtask

    // ---------------- directed + randomized sequence ------------------------
    initial begin
        logic [15:0] data[$];
        logic [31:0] fw;
        int          ch, n, v, waited;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Channel select, including a bad opcode inside CMD.
        send(16'hAABB);
        check("open_busy", bus.busy, 32'h1);
        send(16'hCADC);
        check("bad_op_err", bus.err_pulse, 32'h1);
        send(16'hCA01);
        send(16'hADC2);
        check("sel_ch",  bus.ch_sel,       32'h2);
        check("sel_chv", bus.ch_sel_valid, 32'h1);
        check("sel_err", bus.err_pulse,    32'h0);
        send(16'hBBAA);
        check("close_busy", bus.busy, 32'h0);
        send(16'hAABB);
        send(16'hCA01);
        send(16'hADC7);
        check("bad_sel_err", bus.err_pulse,    32'h1);
        check("bad_sel_ch",  bus.ch_sel,       32'h2);
        check("bad_sel_chv", bus.ch_sel_valid, 32'h1);

        // Frequency word: fixed then random.
        send(16'hCA02);
        send(16'h0012);
        send(16'h3456);
        check("freq_fixed", bus.sample_freq, 32'h00123456);
        fw = $urandom;
        send(16'hCA02);
        send(fw[31:16]);
        send(fw[15:0]);
        check("freq_rand", bus.sample_freq, fw);

        // Point count: zero rejected, large clamped, in-range taken as is.
        send(16'hCA03);
        send(16'h0000);
        check("pts_zero_err", bus.err_pulse,  32'h1);
        check("pts_zero_num", bus.sample_num, 32'(DEFAULT_POINTS));
        send(16'hCA03);
        send(16'hFFFF);
        check("pts_clamp", bus.sample_num, 32'(PTS_MAX));
        v = $urandom_range(PTS_MAX + 1, 16'hFFFF);
        send(16'hCA03);
        send(16'(v));
        check("pts_clamp_rand", bus.sample_num, 32'(PTS_MAX));
        v = $urandom_range(1, PTS_MAX);
        send(16'hCA03);
        send(16'(v));
        check("pts_rand", bus.sample_num, 32'(v));
        send(16'hCA03);
        send(16'd4);
        send(16'hBBAA);
        check("cfg_idle", bus.busy, 32'h0);

        // Abort code in IDLE is just an ignored word.
        send(16'hDEAD);
        check("idle_dead_busy", bus.busy,      32'h0);
        check("idle_dead_err",  bus.err_pulse, 32'h0);

        // Full read with 1,2,3,4 (sum 000A when the checksum is built in).
        data = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_read("read", 4, data, 0);

        // Read without a valid channel is refused.
        send(16'hCCDD);
        check("nosel_err",  bus.err_pulse, 32'h1);
        check("nosel_busy", bus.busy,      32'h0);
        check("nosel_tx",   bus.tx_data,   32'h0);

        // Randomized reads.
        for (int t = 0; t < 3; t++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            n  = $urandom_range(1, 8);
            configure(ch, n);
            check($sformatf("rnd%0d_ch", t),  bus.ch_sel,     32'(ch));
            check($sformatf("rnd%0d_num", t), bus.sample_num, 32'(n));
            data.delete();
            for (int i = 0; i < n; i++) data.push_back(16'($urandom));
            do_read($sformatf("rnd%0d", t), n, data, 0);
        end

        // Underrun: four words captured, FIFO empties after two pops.
        configure(1, 4);
        data.delete();
        for (int i = 0; i < 4; i++) data.push_back(16'($urandom));
        do_read("under", 4, data, 2);

        // Abort during ARM.
        configure(3, 6);
        data.delete();
        fill_src   = data;
        drop_after = 0;
        fill_gen   = fill_gen + 1;
        send(16'hCCDD);
        waited = 0;
        while (bus.fifo_wr_en !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("arm_wren", bus.fifo_wr_en, 32'h1);
        check("arm_tx",   bus.tx_data,    32'hABAD);
        send(16'hDEAD);
        check("abort_wren", bus.fifo_wr_en, 32'h0);
        check("abort_aclr", bus.fifo_aclr,  32'h1);
        check("abort_busy", bus.busy,       32'h0);
        check("abort_tx",   bus.tx_data,    32'h0);
        @(negedge clk);
        check("abort_aclr_one", bus.fifo_aclr, 32'h0);

        // Asynchronous reset in the middle of TX.
        configure(2, 4);
        data.delete();
        for (int i = 0; i < 4; i++) data.push_back(16'($urandom));
        fill_src   = data;
        drop_after = 0;
        fill_gen   = fill_gen + 1;
        send(16'hCCDD);
        waited = 0;
        while (bus.tx_data !== 16'hABCD && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_ready", bus.tx_data, 32'hABCD);
        send(filler());
        check("rst_word0", bus.tx_data, 32'(data[0]));
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/spi_capture_ctrl.md
Name: spi_capture_ctrl

Overview:
- Parametrised command/readout controller between the SPI slave word interface and an N-channel ADC capture FIFO.
- Decodes host command packets that select a channel, set the sample frequency word and set the point count.
- Runs a read transaction: clear FIFO, capture N points, stream them out word by word, then run the end handshake.
- Fully synchronous to one system clock; SPI word strobes arrive as single-cycle enables, not as clocks.

Parameters:
- WORD_W, 16: SPI word width; all protocol codes are WORD_W wide.
- NUM_CH, 4: channel count; select codes are 0xADC0+ch.
- FREQ_W, 32: frequency word width; must be a multiple of WORD_W.
- CNT_W, 13: FIFO used-word count width; FIFO depth is 2^CNT_W.
- DEFAULT_POINTS, 512: sample_num value after reset.
- CLR_CYC, 4: number of cycles fifo_aclr is held high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_valid  in  1  one-cycle strobe; a received word is present
- rx_data  in  WORD_W  received word, valid while rx_valid
- tx_data  out  WORD_W  registered word for the next SPI transfer
- ch_sel  out  $clog2(NUM_CH)  selected channel
- ch_sel_valid  out  1  a channel is selected
- sample_freq  out  FREQ_W  sample frequency word
- sample_num  out  16  points per capture
- fifo_aclr  out  1  FIFO asynchronous clear
- fifo_wr_en  out  1  write enable to the selected ADC path
- fifo_wr_count  in  CNT_W  FIFO used words, write side
- fifo_rd_data  in  WORD_W  show-ahead FIFO output
- fifo_rdempty  in  1  FIFO empty
- fifo_rdreq  out  1  one-cycle FIFO pop
- busy  out  1  high in any state other than IDLE
- err_pulse  out  1  one-cycle error flag

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: tx_data=0, ch_sel=0, ch_sel_valid=0, sample_freq=0, sample_num=DEFAULT_POINTS, fifo_aclr=0, fifo_wr_en=0, fifo_rdreq=0, busy=0, err_pulse=0, state IDLE. Reset mid-transaction aborts immediately to these values.
- State advance: every state transition caused by a word occurs only on a clk edge where rx_valid=1. tx_data updates on that same edge, giving 1-cycle latency.
- IDLE: tx_data<=0. 0xAABB->CMD; 0xCCDD->CLR; any other word is ignored.
- CMD: 0xCA01->SEL (1 word).
- CMD: 0xCA02->FREQ (FREQ_W/WORD_W words, MSW first, shifted into sample_freq).
- CMD: 0xCA03->PTS (1 word).
- CMD: 0xBBAA->IDLE.
- CMD: any other word -> err_pulse, stay in CMD.
- SEL, PTS, FREQ: return to CMD after their last data word.
- SEL: word-0xADC0 < NUM_CH loads ch_sel and sets ch_sel_valid=1. Otherwise err_pulse; ch_sel and ch_sel_valid unchanged.
- PTS: 0 -> err_pulse, sample_num kept. Values >2^CNT_W-1 are clamped to 2^CNT_W-1.
- CLR: fifo_aclr=1 for exactly CLR_CYC cycles, no rx_valid needed; tx_data<=0xABAD.
- CLR: if ch_sel_valid=0 -> err_pulse, IDLE.
- ARM: fifo_wr_en=1; tx_data holds 0xABAD (host polls).
- ARM exit: on the first cycle fifo_wr_count>=sample_num, drop fifo_wr_en, load tx_data<=0xABCD and remain<=sample_num, go TX. This is autonomous; no rx_valid needed.
- TX, rx_valid with remain>0: tx_data<=fifo_rd_data, fifo_rdreq=1 for that cycle, remain-1.
- TX underrun: if fifo_rdempty, tx_data<=0 instead, no pop, err_pulse, remain still decrements.
- TX, rx_valid with remain==0: tx_data<=0xDCBA, go TAIL.
- TAIL, each rx_valid: tx_data<=0. 0xDCAB -> one-cycle fifo_aclr, ch_sel_valid<=0, go IDLE.
- Abort: rx_data==0xDEAD in any non-IDLE state -> fifo_wr_en=0, one-cycle fifo_aclr, tx_data<=0, IDLE. Abort has priority over all other decoding.
- Simultaneous events: if the ARM exit condition and rx_valid coincide, the ARM exit wins and the word is dropped.
- Frequency-word shift: wraps modulo FREQ_W.

Optional Feature:
- Macro: CAPTURE_CHECKSUM_EN.
- Defined: while remain>0, each word popped in TX adds to a 16-bit running sum.
- Defined: the sum is cleared on entry to TX.
- Defined: at remain==0, tx_data<=sum. The following rx_valid presents 0xDCBA and moves to TAIL.
- Undefined: no sum logic; 0xDCBA follows the last data word directly.

Test Plan:
- Channel select: AABB,CADC,CA01,ADC2,BBAA -> ch_sel=2, ch_sel_valid=1, busy back to 0. Repeating with ADC7 (NUM_CH=4) -> err_pulse, ch_sel stays 2.
- Frequency load: AABB,CADC,CA02,0012,3456,BBAA -> sample_freq=0x00123456.
- Points load: CA03,0000 -> err_pulse, sample_num stays 512. CA03,FFFF -> sample_num=8191.
- Full read: sample_num=4, FIFO model fills 1,2,3,4. CCDD -> fifo_aclr high 4 cycles, tx_data=ABAD until count=4, then ABCD. Four strobes -> 1,2,3,4 with 4 rdreq pulses. Next strobe -> DCBA. DCAB -> IDLE. With CAPTURE_CHECKSUM_EN: 000A precedes DCBA.
- Underrun: FIFO empties after 2 words with sample_num=4 -> words 3 and 4 are 0000, err_pulse twice, no rdreq for them.
- Abort/reset: DEAD during ARM -> fifo_wr_en=0, fifo_aclr pulse, IDLE. rst_n low during TX -> all outputs at reset values asynchronously.
